// File: rtl/uart_fifo_tx.sv
// uart_fifo_tx
// ------------
// 8N1 UART transmitter that drains a standard (non-FWFT) synchronous byte
// FIFO. A read is issued only when a new frame is about to start, so the
// FIFO can never underflow. tx_en gates the start of new frames but never
// truncates a frame that is already on the line.
//
// Ports:
//   clk         system clock, single clock domain
//   rst         synchronous reset, active low
//   tx_en       level-sensitive permission to start new frames (e.g. CTS)
//   fifo_empty  FIFO has no data; looked at only while idle
//   fifo_rd_en  one-cycle read strobe to the FIFO
//   fifo_dout   FIFO read data, valid the cycle after fifo_rd_en
//   uart_txd    serial line, idle high
//   busy        high from the read strobe through the last stop-bit cycle
//   byte_done   one-cycle pulse on the final clock of each stop bit
//
// All outputs come straight from flops: the next value of each output is
// derived from the next state, so no input reaches an output combinationally.

module uart_fifo_tx #(
  parameter int CLK_HZ       = 100_000_000,
  parameter int BAUD         = 115_200,
  parameter int CLKS_PER_BIT = (CLK_HZ + BAUD / 2) / BAUD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_en,
  input  logic       fifo_empty,
  output logic       fifo_rd_en,
  input  logic [7:0] fifo_dout,
  output logic       uart_txd,
  output logic       busy,
  output logic       byte_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 2) begin : g_cfg_check
    $error("uart_fifo_tx: CLKS_PER_BIT must be at least 2");
  end

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]    bit_idx_reg, bit_idx_next;
  logic [7:0]    shift_reg, shift_next;
  logic          txd_reg, txd_next;
  logic          rd_en_reg, rd_en_next;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;

  logic bit_last;
  assign bit_last = (cnt_reg == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      txd_reg     <= 1'b1;
      rd_en_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
      txd_reg     <= txd_next;
      rd_en_reg   <= rd_en_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;

    case (state_reg)
      IDLE: begin
        if (tx_en && !fifo_empty) begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        state_next = LOAD;
      end
      LOAD: begin
        // fifo_dout is valid now, one cycle after the read strobe.
        shift_next   = fifo_dout;
        cnt_next     = '0;
        bit_idx_next = '0;
        state_next   = START;
      end
      START: begin
        if (bit_last) begin
          cnt_next   = '0;
          state_next = DATA;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      DATA: begin
        if (bit_last) begin
          cnt_next     = '0;
          shift_next   = {1'b0, shift_reg[7:1]};
          bit_idx_next = bit_idx_reg + 3'd1;
          if (bit_idx_reg == 3'd7) begin
            state_next = STOP;
          end
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      STOP: begin
        if (bit_last) begin
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Output flops are loaded with what the line must show in the next state.
  always_comb begin
    txd_next = 1'b1;
    case (state_next)
      START:   txd_next = 1'b0;
      DATA:    txd_next = shift_next[0];
      default: txd_next = 1'b1;
    endcase
    rd_en_next = (state_next == FETCH);
    busy_next  = (state_next != IDLE);
    done_next  = (state_next == STOP) && (cnt_next == CNT_LAST);
  end

  assign uart_txd   = txd_reg;
  assign fifo_rd_en = rd_en_reg;
  assign busy       = busy_reg;
  assign byte_done  = done_reg;

endmodule
